// File: rtl/arb_requester4.sv
// Requester-side agent for a 4-way rotating-priority arbiter: per-channel job queues,
// req/arb_en generation, beat and job accounting, and grant-protocol checking.
module arb_requester4 #(
  parameter int unsigned BEATS    = 4,
  parameter int unsigned PEND_W   = 3,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_job_push,
  input  logic [3:0] i_gnt,
  output logic [3:0] o_req,
  output logic       o_arb_en,
  output logic       o_beat_valid,
  output logic [1:0] o_beat_ch,
  output logic [3:0] o_job_done,
  output logic       o_idle,
  output logic [3:0] o_ovf,
  output logic       o_err_multi,
  output logic       o_err_spurious,
  output logic [3:0] o_starve
);

  localparam int unsigned BCNT_W = $clog2(BEATS + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT  = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e            r_state [4];
  logic [PEND_W-1:0] r_pend  [4];
  logic [BCNT_W-1:0] r_beat  [4];
  logic [WAIT_W-1:0] r_wait  [4];
  logic [3:0]        r_req;
  logic              r_arb_en;
  logic              r_beat_valid;
  logic [1:0]        r_beat_ch;
  logic [3:0]        r_job_done;
  logic              r_idle;
  logic [3:0]        r_ovf;
  logic              r_err_multi;
  logic              r_err_spurious;
  logic [3:0]        r_starve;

  state_e            w_state_nxt [4];
  logic [PEND_W-1:0] w_pend_nxt  [4];
  logic [BCNT_W-1:0] w_beat_nxt  [4];
  logic [WAIT_W-1:0] w_wait_nxt  [4];
  logic [3:0]        w_beat;
  logic [3:0]        w_last;
  logic [3:0]        w_load;
  logic [3:0]        w_has_pend;
  logic [3:0]        w_ovf_set;
  logic [3:0]        w_req_nxt;
  logic [3:0]        w_starve_nxt;
  logic              w_gnt_multi;
  logic              w_gnt_one;
  logic              w_spurious;
  logic              w_beat_any;
  logic [1:0]        w_beat_ch_nxt;
  logic              w_idle_nxt;

  always_comb begin
    w_gnt_multi   = (i_gnt & (i_gnt - 4'd1)) != 4'd0;
    w_gnt_one     = (i_gnt != 4'd0) && !w_gnt_multi;
    w_spurious    = (i_gnt & ~r_req) != 4'd0;
    w_beat_any    = 1'b0;
    w_beat_ch_nxt = 2'd0;
    w_idle_nxt    = 1'b1;
    w_beat        = '0;
    w_last        = '0;
    w_load        = '0;
    w_has_pend    = '0;
    w_ovf_set     = '0;
    w_req_nxt     = '0;
    w_starve_nxt  = '0;
    for (int i = 0; i < 4; i++) begin
      w_beat[i]      = w_gnt_one && i_gnt[i] && (r_state[i] == ST_ACTIVE);
      w_last[i]      = w_beat[i] && (r_beat[i] == BEAT_LAST);
      w_has_pend[i]  = r_pend[i] != '0;
      w_state_nxt[i] = r_state[i];
      w_beat_nxt[i]  = r_beat[i];

      if (r_state[i] == ST_IDLE) begin
        // A push into an empty queue is taken straight into the FSM
        if (w_has_pend[i] || i_job_push[i]) begin
          w_load[i]      = 1'b1;
          w_state_nxt[i] = ST_ACTIVE;
          w_beat_nxt[i]  = '0;
        end
      end else if (w_last[i]) begin
        w_beat_nxt[i] = '0;
        if (w_has_pend[i]) begin
          w_load[i] = 1'b1;
        end else begin
          w_state_nxt[i] = ST_IDLE;
        end
      end else if (w_beat[i]) begin
        w_beat_nxt[i] = r_beat[i] + 1'b1;
      end

      w_pend_nxt[i] = r_pend[i];
      if (i_job_push[i] && !w_load[i]) begin
        if (r_pend[i] == PEND_MAX) begin
          w_ovf_set[i] = 1'b1;
        end else begin
          w_pend_nxt[i] = r_pend[i] + 1'b1;
        end
      end else if (!i_job_push[i] && w_load[i]) begin
        w_pend_nxt[i] = r_pend[i] - 1'b1;
      end

      if ((r_state[i] == ST_ACTIVE) && !w_beat[i]) begin
        w_wait_nxt[i] = (r_wait[i] == WAIT_SAT) ? r_wait[i] : r_wait[i] + 1'b1;
      end else begin
        w_wait_nxt[i] = '0;
      end

      w_req_nxt[i]    = w_state_nxt[i] == ST_ACTIVE;
      w_starve_nxt[i] = w_wait_nxt[i] >= WAIT_SAT;
      if (w_beat[i]) begin
        w_beat_any    = 1'b1;
        w_beat_ch_nxt = 2'(i);
      end
      if ((w_state_nxt[i] != ST_IDLE) || (w_pend_nxt[i] != '0)) begin
        w_idle_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= ST_IDLE;
        r_pend[i]  <= '0;
        r_beat[i]  <= '0;
        r_wait[i]  <= '0;
      end
      r_req          <= '0;
      r_arb_en       <= 1'b0;
      r_beat_valid   <= 1'b0;
      r_beat_ch      <= 2'd0;
      r_job_done     <= '0;
      r_idle         <= 1'b0;
      r_ovf          <= '0;
      r_err_multi    <= 1'b0;
      r_err_spurious <= 1'b0;
      r_starve       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_pend[i]  <= w_pend_nxt[i];
        r_beat[i]  <= w_beat_nxt[i];
        r_wait[i]  <= w_wait_nxt[i];
      end
      r_req          <= w_req_nxt;
      r_arb_en       <= |w_req_nxt;
      r_beat_valid   <= w_beat_any;
      r_beat_ch      <= w_beat_ch_nxt;
      r_job_done     <= w_last;
      r_idle         <= w_idle_nxt;
      r_ovf          <= r_ovf | w_ovf_set;
      r_err_multi    <= r_err_multi | w_gnt_multi;
      r_err_spurious <= r_err_spurious | w_spurious;
      r_starve       <= w_starve_nxt;
    end
  end

  assign o_req          = r_req;
  assign o_arb_en       = r_arb_en;
  assign o_beat_valid   = r_beat_valid;
  assign o_beat_ch      = r_beat_ch;
  assign o_job_done     = r_job_done;
  assign o_idle         = r_idle;
  assign o_ovf          = r_ovf;
  assign o_err_multi    = r_err_multi;
  assign o_err_spurious = r_err_spurious;
  assign o_starve       = r_starve;

endmodule
